regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file with write-to-read bypass and an integrated per-register scoreboard. It replaces the fixed 2-read/1-write register file in the ID stage. The issue logic reserves destination registers, and the WB stage writes results and clears the matching reservations. Read ports report both operand data and whether that operand is still pending.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; register count NREG = 2**ADDR_W; register 0 is hard-wired to zero
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
---
- Reset is synchronous, active-high; one clock.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- we  in  NUM_WR  per-port write enable
- waddr  in  NUM_WR*ADDR_W  write addresses, port i at bits [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data, packed the same way
- re  in  NUM_RD  per-port read enable
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data (combinational)
- rbusy  out  NUM_RD  operand still pending (combinational)
- rsv_en  in  1  request to reserve a destination register
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- flush  in  1  clear all pending bits (pipeline flush)
- pend_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: NREG x DATA_W array. Register 0 is never written, always reads 0, and is never pending.
- Write: for each port i with we[i]=1 and waddr!=0, the register takes wdata at the edge. If several ports target the same address, the highest port index wins.
- Read port j:
  - re[j]=0 or raddr=0: rdata=0, rbusy=0.
  - Bypass: if a write this cycle targets raddr, rdata is that write's data (highest-index port) and rbusy=0.
  - Otherwise rdata is the stored value and rbusy=pending[raddr].
- Scoreboard: one pending bit per register.
  - rsv_ok = rsv_en & !flush & (rsv_addr==0 | !pending[rsv_addr] | a write clears rsv_addr this cycle).
  - Accepted reservation to a nonzero address sets the bit at the edge. Reserving address 0 is accepted but has no effect.
  - A write clears the bit for its address.
  - Reservation and write to the same address in one cycle: the bit ends up 1 (new producer).
  - A refused reservation (rsv_ok=0) leaves state unchanged. Issue logic must stall and retry; this prevents WAW hazards.
- flush: clears all pending bits at the edge and overrides same-cycle reservations. Writes in that cycle still update the data array.
- pend_cnt: registered population count of the pending bits, updated every edge.

## Timing
- Read, bypass, rbusy and rsv_ok: 0-cycle combinational.
- Write visible in storage one edge after we.
- Pending set/clear visible on rbusy and rsv_ok the cycle after the edge. Same-cycle effects come only via the bypass and the clearing-write term.
- Reset (rst=1 at edge): all registers=0, all pending=0, pend_cnt=0.
- While rst is high: rdata=0, rbusy=0, rsv_ok=0, and writes and reservations are ignored.
- Reset asserted mid-operation discards all outstanding reservations.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding as described above.
- Undefined:
  - Reads return the stored (old) value.
  - rbusy stays 1 for a pending register even while it is being written.
  - rsv_ok ignores the clearing-write term.
  - The consumer sees new data one cycle later.

## Structure
- The shared defines header holds RstEnable, WriteEnable, ReadEnable and ZeroWord. New constants REGFILE_DATA_W and REGFILE_ADDR_W also go there.
- Sub-module regfile_scoreboard: pending bits, rsv_ok logic, flush handling and pend_cnt. The top level keeps the storage array, write priority and read/bypass muxes.

## Test plan
- Reset, then read r1..r31 on both ports -> rdata=0, rbusy=0, pend_cnt=0.
- Write r5=0xDEADBEEF on port 0 and read r5 in the same cycle:
  - With REGFILE_BYPASS_EN: rdata=0xDEADBEEF that cycle.
  - Without it: 0 that cycle, 0xDEADBEEF the next.
- Ports 0 and 1 write r7=0x11 and r7=0x22 in the same cycle -> r7 reads 0x22.
- Write r0=0xFFFFFFFF; reserve r0 -> r0 reads 0, rbusy=0, pend_cnt unchanged.
- Reserve r3 (rsv_ok=1); next cycle:
  - rbusy on r3 = 1.
  - Re-reserve r3 -> rsv_ok=0.
  - Write r3 together with re-reserving r3 -> rsv_ok=1, pending stays 1, pend_cnt=1.
- Reserve r2, r4, r6 (pend_cnt=3), then assert flush together with reserving r8 -> rsv_ok=0 and next cycle pend_cnt=0. Repeat with rst instead of flush -> all registers 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared constants for the multi-port register file
//
// Shared constants imported by every regfile_mp file:
//   RstEnable, WriteEnable, ReadEnable : active levels of reset, write and read enables
//   ZeroWord                           : all-zero data word
//   REGFILE_DATA_W, REGFILE_ADDR_W     : default register width and address width
// nreg() turns an address width into a register count.
package regfile_mp_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_ADDR_W = 5;

  function automatic int nreg(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - bundled write, read and scoreboard signals of regfile_mp
//
// Signals (the master drives requests, the slave is the register file):
//   we, waddr, wdata    : NUM_WR write ports, port i at [i*W +: W]
//   re, raddr           : NUM_RD read ports
//   rdata, rbusy        : read data and operand-pending flag per read port
//   rsv_en, rsv_addr    : destination reservation request
//   rsv_ok              : reservation accepted this cycle
//   flush               : drop all pending reservations
//   pend_cnt            : registered count of pending registers
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic                     flush;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output we, waddr, wdata, re, raddr, rsv_en, rsv_addr, flush,
    input  rdata, rbusy, rsv_ok, pend_cnt
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, rsv_en, rsv_addr, flush,
    output rdata, rbusy, rsv_ok, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits, reservation accept and pending count
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   rsv_en_i    : reservation request
//   rsv_addr_i  : register to reserve
//   flush_i     : clear every pending bit at the edge
//   wclr_i      : one bit per register, set when a write lands on it this cycle
//   pending_o   : current pending bits
//   rsv_ok_o    : reservation accepted this cycle (combinational)
//   pend_cnt_o  : registered population count of the pending bits
// Build option REGFILE_BYPASS_EN lets a same-cycle clearing write free the
// register for a new reservation.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NREG   = nreg(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic              flush_i,
  input  logic [NREG-1:0]   wclr_i,
  output logic [NREG-1:0]   pending_o,
  output logic              rsv_ok_o,
  output logic [ADDR_W:0]   pend_cnt_o
);

  logic [NREG-1:0] pend_q, pend_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            rst_act;
  logic            clr_hit;

  assign rst_act = (rst == RstEnable);

`ifdef REGFILE_BYPASS_EN
  // The current producer is retiring this very cycle, so the register can be
  // handed to the next producer without a stall.
  assign clr_hit = wclr_i[rsv_addr_i];
`else
  assign clr_hit = 1'b0;
`endif

  assign rsv_ok_o = !rst_act && rsv_en_i && !flush_i &&
                    ((rsv_addr_i == '0) || !pend_q[rsv_addr_i] || clr_hit);

  always_comb begin
    pend_d = pend_q & ~wclr_i;
    // Set after clear: a reservation racing a write marks the new producer.
    if (rsv_ok_o && (rsv_addr_i != '0)) begin
      pend_d[rsv_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  // Count the next-state bits so the count lines up with the pending bits.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_act) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o  = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write-to-read bypass and scoreboard
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : regfile_mp_if.slave (write ports, read ports, reservation, flush, pend_cnt)
// Register 0 reads as zero, is never written and is never pending.
// When several write ports hit one address, the highest port index wins.
// Build option REGFILE_BYPASS_EN forwards same-cycle write data to readers and
// hides the pending flag of a register being written.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int NREG = nreg(ADDR_W);

  logic              rst_act;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   wr_hit;
  logic [DATA_W-1:0] wr_val [NREG];
  logic [NREG-1:0]   pending;
  logic [NUM_RD*DATA_W-1:0] rdata_d;
  logic [NUM_RD-1:0]        rbusy_d;

  assign rst_act = (rst == RstEnable);

  // Resolve all write ports into one write per register; later (higher index)
  // ports overwrite earlier ones, which gives the highest port priority.
  always_comb begin
    logic [ADDR_W-1:0] wa;
    wa     = '0;
    wr_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      wr_val[r] = '0;
    end
    if (!rst_act) begin
      for (int i = 0; i < NUM_WR; i++) begin
        wa = bus.waddr[i*ADDR_W +: ADDR_W];
        if ((bus.we[i] == WriteEnable) && (wa != '0)) begin
          wr_hit[wa] = 1'b1;
          wr_val[wa] = bus.wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_act) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra      = '0;
    rdata_d = '0;
    rbusy_d = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      ra = bus.raddr[j*ADDR_W +: ADDR_W];
      if (!rst_act && (bus.re[j] == ReadEnable) && (ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_hit[ra]) begin
          rdata_d[j*DATA_W +: DATA_W] = wr_val[ra];
          rbusy_d[j]                  = 1'b0;
        end else begin
          rdata_d[j*DATA_W +: DATA_W] = regs_q[ra];
          rbusy_d[j]                  = pending[ra];
        end
`else
        rdata_d[j*DATA_W +: DATA_W] = regs_q[ra];
        rbusy_d[j]                  = pending[ra];
`endif
      end
    end
  end

  assign bus.rdata = rdata_d;
  assign bus.rbusy = rbusy_d;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .flush_i    (bus.flush),
    .wclr_i     (wr_hit),
    .pending_o  (pending),
    .rsv_ok_o   (bus.rsv_ok),
    .pend_cnt_o (bus.pend_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with a behavioural model
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int NREG = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] m_mem  [NREG];
  bit          m_pend [NREG];
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest-index write port aimed at a nonzero address a this cycle.
  function automatic bit m_written(input logic [4:0] a, output logic [31:0] d);
    bit hit = 1'b0;
    d = 32'h0;
    for (int i = 0; i < NW; i++) begin
      if (bus.we[i] && bus.waddr[i*AW +: AW] == a && a != 5'd0) begin
        hit = 1'b1;
        d   = bus.wdata[i*DW +: DW];
      end
    end
    return hit;
  endfunction

  function automatic logic [31:0] m_rdata(input int j);
    logic [4:0]  a = bus.raddr[j*AW +: AW];
    logic [31:0] d;
    if (rst || !bus.re[j] || a == 5'd0) return 32'h0;
    if (BYP && m_written(a, d)) return d;
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input int j);
    logic [4:0]  a = bus.raddr[j*AW +: AW];
    logic [31:0] d;
    if (rst || !bus.re[j] || a == 5'd0) return 1'b0;
    if (BYP && m_written(a, d)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic logic m_rsv_ok();
    logic [4:0]  a = bus.rsv_addr;
    logic [31:0] d;
    if (rst || !bus.rsv_en || bus.flush) return 1'b0;
    return (a == 5'd0) || !m_pend[a] || (BYP && m_written(a, d));
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += m_pend[r];
    return c;
  endfunction

  task automatic model_update();
    bit ok = m_rsv_ok();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r]  = 32'h0;
        m_pend[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        logic [4:0] a = bus.waddr[i*AW +: AW];
        if (bus.we[i] && a != 5'd0) begin
          m_mem[a]  = bus.wdata[i*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (bus.flush) begin
        for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
      end else if (ok && bus.rsv_addr != 5'd0) begin
        m_pend[bus.rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.re = '0; bus.raddr = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.flush = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < NR; j++) begin
        check($sformatf("rdata%0d", j), bus.rdata[j*DW +: DW], m_rdata(j));
        check($sformatf("rbusy%0d", j), {31'h0, bus.rbusy[j]}, {31'h0, m_rbusy(j)});
      end
      check("rsv_ok", {31'h0, bus.rsv_ok}, {31'h0, m_rsv_ok()});
      check("pend_cnt", {26'h0, bus.pend_cnt}, 32'(m_cnt()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    #2 check("rst_pend_cnt", {26'h0, bus.pend_cnt}, 32'h0);

    for (int r = 1; r < NREG; r++) begin
      bus.re = 2'b11;
      bus.raddr = {5'(r), 5'(r)};
      #2;
      check("rst_rd0", bus.rdata[31:0], 32'h0);
      check("rst_rd1", bus.rdata[63:32], 32'h0);
      check("rst_busy", {30'h0, bus.rbusy}, 32'h0);
      tick();
    end

    idle();
    bus.we = 2'b01; bus.waddr[4:0] = 5'd5; bus.wdata[31:0] = 32'hDEADBEEF;
    bus.re = 2'b01; bus.raddr[4:0] = 5'd5;
    #2 check("r5_same_cycle", bus.rdata[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    bus.we = 2'b00;
    #2 check("r5_next_cycle", bus.rdata[31:0], 32'hDEADBEEF);
    tick();

    idle();
    bus.we = 2'b11; bus.waddr = {5'd7, 5'd7}; bus.wdata = {32'h22, 32'h11};
    tick();
    idle();
    bus.re = 2'b01; bus.raddr[4:0] = 5'd7;
    #2 check("r7_port_prio", bus.rdata[31:0], 32'h22);
    tick();

    idle();
    bus.we = 2'b01; bus.waddr[4:0] = 5'd0; bus.wdata[31:0] = 32'hFFFFFFFF;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    #2 check("rsv_r0_ok", {31'h0, bus.rsv_ok}, 32'h1);
    tick();
    idle();
    bus.re = 2'b11; bus.raddr = {5'd0, 5'd0};
    #2;
    check("r0_data", bus.rdata[31:0], 32'h0);
    check("r0_busy", {30'h0, bus.rbusy}, 32'h0);
    check("r0_pend_cnt", {26'h0, bus.pend_cnt}, 32'h0);
    tick();

    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    #2 check("rsv_r3_ok", {31'h0, bus.rsv_ok}, 32'h1);
    tick();
    bus.re = 2'b01; bus.raddr[4:0] = 5'd3;
    #2;
    check("r3_busy", {31'h0, bus.rbusy[0]}, 32'h1);
    check("r3_rersv_refused", {31'h0, bus.rsv_ok}, 32'h0);
    check("r3_pend_cnt", {26'h0, bus.pend_cnt}, 32'h1);
    tick();
    bus.we = 2'b01; bus.waddr[4:0] = 5'd3; bus.wdata[31:0] = 32'h33;
    #2 check("r3_wr_rersv", {31'h0, bus.rsv_ok}, BYP ? 32'h1 : 32'h0);
    tick();
    idle();
    #2 check("r3_pend_after", {26'h0, bus.pend_cnt}, BYP ? 32'h1 : 32'h0);
    bus.we = 2'b01; bus.waddr[4:0] = 5'd3; bus.wdata[31:0] = 32'h34;
    tick();
    idle();
    #2 check("r3_cleared", {26'h0, bus.pend_cnt}, 32'h0);

    for (int k = 1; k <= 3; k++) begin
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'(2 * k);
      tick();
    end
    idle();
    #2 check("three_pending", {26'h0, bus.pend_cnt}, 32'h3);
    bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
    #2 check("flush_rsv_refused", {31'h0, bus.rsv_ok}, 32'h0);
    tick();
    idle();
    bus.re = 2'b01; bus.raddr[4:0] = 5'd2;
    #2;
    check("flush_pend_cnt", {26'h0, bus.pend_cnt}, 32'h0);
    check("flush_r2_busy", {31'h0, bus.rbusy[0]}, 32'h0);
    idle();

    for (int k = 1; k <= 3; k++) begin
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'(2 * k);
      tick();
    end
    idle();
    bus.we = 2'b10; bus.waddr[9:5] = 5'd9; bus.wdata[63:32] = 32'h99;
    tick();
    idle();
    #2 check("pre_rst_pend_cnt", {26'h0, bus.pend_cnt}, 32'h3);
    rst = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
    #2 check("rst_rsv_refused", {31'h0, bus.rsv_ok}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    bus.re = 2'b11; bus.raddr = {5'd7, 5'd5};
    #2;
    check("rst2_pend_cnt", {26'h0, bus.pend_cnt}, 32'h0);
    check("rst2_r5", bus.rdata[31:0], 32'h0);
    check("rst2_r7", bus.rdata[63:32], 32'h0);
    tick();
    bus.raddr = {5'd9, 5'd9};
    #2 check("rst2_r9", bus.rdata[31:0], 32'h0);
    tick();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NW; i++) begin
        bus.we[i] = 1'($urandom_range(0, 1));
        bus.waddr[i*AW +: AW] = rand_addr();
        bus.wdata[i*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NR; j++) begin
        bus.re[j] = ($urandom_range(0, 3) != 0);
        bus.raddr[j*AW +: AW] = rand_addr();
      end
      bus.rsv_en = 1'($urandom_range(0, 1));
      bus.rsv_addr = rand_addr();
      tick();
    end

    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
